// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: sequencer phase encodings, opcodes and instruction-class helpers.
package cpu_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned OPC_W   = 4;

  localparam logic [PHASE_W-1:0] FETCH     = 3'd0;
  localparam logic [PHASE_W-1:0] DECODE    = 3'd1;
  localparam logic [PHASE_W-1:0] EXECUTE   = 3'd2;
  localparam logic [PHASE_W-1:0] WRITEBACK = 3'd3;
  localparam logic [PHASE_W-1:0] OUTPUT    = 3'd4;

  localparam logic [OPC_W-1:0] NOP  = 4'h0;
  localparam logic [OPC_W-1:0] LOAD = 4'hA;

  // Instruction classes by opcode: register ops 1-7, immediate ops 8-B (incl. LOAD), output ops C-F.
  function automatic logic is_rtype(input logic [7:0] instr);
    return (instr[3] == 1'b0) && (instr[3:0] != NOP);
  endfunction

  function automatic logic is_itype(input logic [7:0] instr);
    return instr[3:2] == 2'b10;
  endfunction

  function automatic logic is_otype(input logic [7:0] instr);
    return instr[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Five-phase instruction sequencer: latches one instruction per handshake, steps the phases for
// control_lut, provides the result handshake and counts retired instructions.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned STATE_W = PHASE_W,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [STATE_W-1:0] state,
  output logic [INSTR_W-1:0] instr_q,
  output logic               busy,
  output logic [CNT_W-1:0]   retired_cnt
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [INSTR_W-1:0] r_instr_q;
  logic [CNT_W-1:0]   r_retired_cnt;
  logic               w_accept;
  logic               w_retire;

  // State register; ena=0 freezes the phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake qualifiers (ena gates the registers, so it is only needed on the strobes).
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      FETCH: begin
        if (instr_valid) begin
          w_state_nxt = DECODE;
          w_accept    = ena;
        end
      end
      DECODE:    w_state_nxt = EXECUTE;
      EXECUTE: begin
        if (r_instr_q == '0) begin
          w_state_nxt = FETCH;
          w_retire    = ena;
        end else begin
          w_state_nxt = WRITEBACK;
        end
      end
      WRITEBACK: w_state_nxt = OUTPUT;
      OUTPUT: begin
        if (out_ready) begin
          w_state_nxt = FETCH;
          w_retire    = ena;
        end
      end
      default:   w_state_nxt = FETCH;
    endcase
  end

  // Handshake and status outputs decoded from the current phase.
  always_comb begin
    instr_ready = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    if (r_state == FETCH) begin
      instr_ready = 1'b1;
      busy        = 1'b0;
    end
    if (r_state == OUTPUT) begin
      out_valid = 1'b1;
    end
  end

  // Instruction register, written only on an accepted FETCH handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr_q <= '0;
    end else if (w_accept) begin
      r_instr_q <= instr_in;
    end
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired_cnt <= '0;
    end else if (w_retire) begin
      r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end
  end

  assign state       = r_state;
  assign instr_q     = r_instr_q;
  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: inputs change and outputs are checked on the falling edge.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] instr_in;
  logic       instr_valid;
  logic       instr_ready;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] state;
  logic [7:0] instr_q;
  logic       busy;
  logic [7:0] retired_cnt;

  int n_cmp;
  int n_err;

  cpu_sequencer #(.INSTR_W(8), .STATE_W(3), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .state       (state),
    .instr_q     (instr_q),
    .busy        (busy),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    rst_n = 1'b0; ena = 1'b1; instr_valid = 1'b0; instr_in = 8'h00; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_cmp++; if (instr_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_hs got rdy=%b vld=%b busy=%b exp 1 0 0", instr_ready, out_valid, busy); end
    n_cmp++; if (instr_q !== 8'h00 || retired_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_regs got q=%h cnt=%0d exp 00 0", instr_q, retired_cnt); end
    // Run an instruction into OUTPUT, then reset while stalled there.
    rst_n = 1'b1; instr_valid = 1'b1; instr_in = 8'h41;
    for (int i = 0; i < 4; i++) begin
      tick(); instr_valid = 1'b0;
      n_cmp++; if (state !== exp_st[i]) begin n_err++; $display("FAIL reset_walk[%0d] got %0d exp %0d", i, state, exp_st[i]); end
    end
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (state !== 3'd0 || instr_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_midout got st=%0d rdy=%b vld=%b exp 0 1 0", state, instr_ready, out_valid); end
    n_cmp++; if (retired_cnt !== 8'd0 || instr_q !== 8'h00) begin
      n_err++; $display("FAIL reset_midout_regs got cnt=%0d q=%h exp 0 00", retired_cnt, instr_q); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    int ov_cnt = 0;
    instr_valid = 1'b1; instr_in = 8'h41; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); instr_valid = 1'b0; instr_in = 8'hFF;
      if (out_valid === 1'b1) ov_cnt++;
      n_cmp++; if (state !== exp_st[i]) begin n_err++; $display("FAIL normal_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
    end
    n_cmp++; if (ov_cnt != 1) begin n_err++; $display("FAIL normal_outvalid_cycles got %0d exp 1", ov_cnt); end
    n_cmp++; if (retired_cnt !== 8'd1) begin n_err++; $display("FAIL normal_retired got %0d exp 1", retired_cnt); end
    n_cmp++; if (instr_q !== 8'h41) begin n_err++; $display("FAIL normal_instr_q got %h exp 41", instr_q); end
  endtask

  task automatic test_nop();
    logic [2:0] exp_st [3] = '{3'd1, 3'd2, 3'd0};
    int ov_cnt = 0;
    instr_valid = 1'b1; instr_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick(); instr_valid = 1'b0;
      if (out_valid === 1'b1) ov_cnt++;
      n_cmp++; if (state !== exp_st[i]) begin n_err++; $display("FAIL nop_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
    end
    n_cmp++; if (ov_cnt != 0) begin n_err++; $display("FAIL nop_outvalid got %0d cycles exp 0", ov_cnt); end
    n_cmp++; if (retired_cnt !== 8'd2) begin n_err++; $display("FAIL nop_retired got %0d exp 2", retired_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; instr_valid = 1'b1; instr_in = 8'h5C;
    tick(); tick(); tick(); tick();
    // instr_valid stays high and instr_in toggles: both must be ignored after acceptance.
    for (int i = 0; i < 5; i++) begin
      instr_in = 8'(8'hA0 + i);
      tick();
      n_cmp++; if (state !== 3'd4 || out_valid !== 1'b1 || instr_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d] got st=%0d vld=%b rdy=%b exp 4 1 0", i, state, out_valid, instr_ready); end
      n_cmp++; if (instr_q !== 8'h5C) begin n_err++; $display("FAIL bp_instr_q[%0d] got %h exp 5c", i, instr_q); end
    end
    out_ready = 1'b1; instr_in = 8'h33;
    tick();
    n_cmp++; if (state !== 3'd0 || instr_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release got st=%0d rdy=%b exp 0 1", state, instr_ready); end
    n_cmp++; if (retired_cnt !== 8'd3 || instr_q !== 8'h5C) begin
      n_err++; $display("FAIL bp_no_early_accept got cnt=%0d q=%h exp 3 5c", retired_cnt, instr_q); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_st [4] = '{3'd2, 3'd3, 3'd4, 3'd0};
    tick();
    instr_valid = 1'b0;
    n_cmp++; if (state !== 3'd1 || instr_q !== 8'h33) begin
      n_err++; $display("FAIL b2b_accept got st=%0d q=%h exp 1 33", state, instr_q); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (state !== exp_st[i]) begin n_err++; $display("FAIL b2b_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
    end
    n_cmp++; if (retired_cnt !== 8'd4) begin n_err++; $display("FAIL b2b_retired got %0d exp 4", retired_cnt); end
  endtask

  task automatic test_enable();
    instr_valid = 1'b1; instr_in = 8'h12; out_ready = 1'b1;
    tick(); instr_valid = 1'b0;
    tick();
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL en_reach_exec got %0d exp 2", state); end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (state !== 3'd2 || retired_cnt !== 8'd4) begin
        n_err++; $display("FAIL en_freeze[%0d] got st=%0d cnt=%0d exp 2 4", i, state, retired_cnt); end
    end
    ena = 1'b1;
    tick();
    n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL en_resume got %0d exp 3", state); end
    tick(); tick();
    n_cmp++; if (state !== 3'd0 || retired_cnt !== 8'd5) begin
      n_err++; $display("FAIL en_complete got st=%0d cnt=%0d exp 0 5", state, retired_cnt); end
    // Handshake offered with ena=0 must not be taken.
    ena = 1'b0; instr_valid = 1'b1; instr_in = 8'h77;
    tick();
    ena = 1'b1; instr_valid = 1'b0;
    tick();
    n_cmp++; if (state !== 3'd0 || instr_q !== 8'h12) begin
      n_err++; $display("FAIL en_no_accept got st=%0d q=%h exp 0 12", state, instr_q); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      instr_valid = 1'b1; instr_in = 8'h00;
      tick(); instr_valid = 1'b0;
      tick(); tick();
      if (n == 255) begin
        n_cmp++; if (retired_cnt !== 8'd255) begin n_err++; $display("FAIL wrap_255 got %0d exp 255", retired_cnt); end
      end
    end
    n_cmp++; if (retired_cnt !== 8'd0 || state !== 3'd0) begin
      n_err++; $display("FAIL wrap_zero got cnt=%0d st=%0d exp 0 0", retired_cnt, state); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; ena = 1'b1; instr_in = 8'h00; instr_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_normal();
    test_nop();
    test_backpressure();
    test_back_to_back();
    test_enable();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
